// File: rtl/sodor_mem_responder.sv
// Three-port word memory responder for the Sodor cores: master_port_0 (read-only),
// master_port_1 and debug_port. Requests are always accepted. Each response
// emerges through a fixed LATENCY-deep pipeline on its own port.
module sodor_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        io_master_port_0_req_valid,
    input  logic [31:0] io_master_port_0_req_bits_addr,
    input  logic [31:0] io_master_port_0_req_bits_data,
    input  logic        io_master_port_0_req_bits_fcn,
    input  logic [2:0]  io_master_port_0_req_bits_typ,
    output logic        io_master_port_0_resp_valid,
    output logic [31:0] io_master_port_0_resp_bits_data,

    input  logic        io_master_port_1_req_valid,
    input  logic [31:0] io_master_port_1_req_bits_addr,
    input  logic [31:0] io_master_port_1_req_bits_data,
    input  logic        io_master_port_1_req_bits_fcn,
    input  logic [2:0]  io_master_port_1_req_bits_typ,
    output logic        io_master_port_1_resp_valid,
    output logic [31:0] io_master_port_1_resp_bits_data,

    input  logic        io_debug_port_req_valid,
    input  logic [31:0] io_debug_port_req_bits_addr,
    input  logic [31:0] io_debug_port_req_bits_data,
    input  logic        io_debug_port_req_bits_fcn,
    input  logic [2:0]  io_debug_port_req_bits_typ,
    output logic        io_debug_port_resp_valid,
    output logic [31:0] io_debug_port_resp_bits_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int NP = 3;

    // Port 0 = master_port_0, 1 = master_port_1, 2 = debug_port.
    logic [NP-1:0] reqValid;
    logic [NP-1:0] reqFcn;
    logic [31:0]   reqAddr [NP];
    logic [31:0]   reqData [NP];
    logic [2:0]    reqTyp  [NP];

    assign reqValid   = {io_debug_port_req_valid, io_master_port_1_req_valid, io_master_port_0_req_valid};
    assign reqFcn     = {io_debug_port_req_bits_fcn, io_master_port_1_req_bits_fcn, io_master_port_0_req_bits_fcn};
    assign reqAddr[0] = io_master_port_0_req_bits_addr;
    assign reqAddr[1] = io_master_port_1_req_bits_addr;
    assign reqAddr[2] = io_debug_port_req_bits_addr;
    assign reqData[0] = io_master_port_0_req_bits_data;
    assign reqData[1] = io_master_port_1_req_bits_data;
    assign reqData[2] = io_debug_port_req_bits_data;
    assign reqTyp[0]  = io_master_port_0_req_bits_typ;
    assign reqTyp[1]  = io_master_port_1_req_bits_typ;
    assign reqTyp[2]  = io_debug_port_req_bits_typ;

    // Address bits above the array wrap around (aliasing), so they are deliberately dropped.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{reqAddr[0][31:AW+2], reqAddr[1][31:AW+2], reqAddr[2][31:AW+2]};

    // Byte enables for a store: typ 1/5 byte, 2/6 halfword, anything else a full word.
    function automatic logic [3:0] byteEnable(input logic [2:0] typ, input logic [1:0] off);
        logic [3:0] be;
        case (typ)
            3'd1, 3'd5: be = 4'b0001 << off;
            3'd2, 3'd6: be = off[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the low byte/halfword of the store data across every lane.
    function automatic logic [31:0] laneData(input logic [2:0] typ, input logic [31:0] data);
        logic [31:0] lanes;
        case (typ)
            3'd1, 3'd5: lanes = {4{data[7:0]}};
            3'd2, 3'd6: lanes = {2{data[15:0]}};
            default:    lanes = data;
        endcase
        return lanes;
    endfunction

    // Right-justify the addressed lane; B/H sign-extend, BU/HU zero-extend.
    function automatic logic [31:0] formatRead(input logic [31:0] word, input logic [2:0] typ,
                                               input logic [1:0] off);
        logic [31:0]        shifted;
        logic signed [7:0]  sByte;
        logic signed [15:0] sHalf;
        logic [31:0]        res;
        shifted = word >> {off, 3'b000};
        sByte   = shifted[7:0];
        sHalf   = off[1] ? word[31:16] : word[15:0];
        case (typ)
            3'd1:    res = 32'(sByte);
            3'd5:    res = {24'd0, sByte};
            3'd2:    res = 32'(sHalf);
            3'd6:    res = {16'd0, sHalf};
            default: res = word;
        endcase
        return res;
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wordIdx [NP];
    logic [NP-1:0] accept;
    logic [NP-1:0] doWrite;
    logic [3:0]    byteEn  [NP];
    logic [31:0]   wrLanes [NP];
    logic [31:0]   respFmt [NP];

    // Decode each request and sample the array before this cycle's writes land.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            wordIdx[p] = reqAddr[p][AW+1:2];
            accept[p]  = reqValid[p] & reset;
            doWrite[p] = accept[p] & reqFcn[p] & (p != 0);
            byteEn[p]  = byteEnable(reqTyp[p], reqAddr[p][1:0]);
            wrLanes[p] = laneData(reqTyp[p], reqData[p]);
            respFmt[p] = doWrite[p] ? 32'd0
                                    : formatRead(mem[wordIdx[p]], reqTyp[p], reqAddr[p][1:0]);
        end
    end

    // Commit writes; master_port_1 is issued first so debug bytes win on overlap.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (doWrite[1] && byteEn[1][b])
                mem[wordIdx[1]][8*b +: 8] <= wrLanes[1][8*b +: 8];
            if (doWrite[2] && byteEn[2][b])
                mem[wordIdx[2]][8*b +: 8] <= wrLanes[2][8*b +: 8];
        end
    end

    logic [LATENCY-1:0] respVld_p  [NP];
    logic [31:0]        respData_p [NP][LATENCY];

    // Response valid pipeline; reset flushes everything in flight.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NP; p++) begin
            if (!reset) begin
                respVld_p[p] <= '0;
            end else begin
                respVld_p[p][0] <= accept[p];
                for (int s = 1; s < LATENCY; s++)
                    respVld_p[p][s] <= respVld_p[p][s-1];
            end
        end
    end

    // Response data pipeline; contents only matter where the matching valid is set.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NP; p++) begin
            respData_p[p][0] <= respFmt[p];
            for (int s = 1; s < LATENCY; s++)
                respData_p[p][s] <= respData_p[p][s-1];
        end
    end

    logic [NP-1:0] respValid;
    logic [31:0]   respOut [NP];

    // Final stage drives the ports; data is forced to zero when no response is due.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            respValid[p] = respVld_p[p][LATENCY-1];
            respOut[p]   = respVld_p[p][LATENCY-1] ? respData_p[p][LATENCY-1] : 32'd0;
        end
    end

    assign io_master_port_0_resp_valid     = respValid[0];
    assign io_master_port_0_resp_bits_data = respOut[0];
    assign io_master_port_1_resp_valid     = respValid[1];
    assign io_master_port_1_resp_bits_data = respOut[1];
    assign io_debug_port_resp_valid        = respValid[2];
    assign io_debug_port_resp_bits_data    = respOut[2];

endmodule

// File: tb/tb_sodor_mem_responder.sv
// Directed bench for sodor_mem_responder: a vector table for single requests
// plus hand-written sequences for same-cycle hazards and mid-flight reset.
module tb_sodor_mem_responder;

    localparam int LAT = 3;

    logic clock;
    logic reset;
    logic [2:0]       pValid;
    logic [2:0]       pFcn;
    logic [2:0][31:0] pAddr;
    logic [2:0][31:0] pData;
    logic [2:0][2:0]  pTyp;
    logic [2:0]       rValid;
    logic [2:0][31:0] rData;

    int tests;
    int failed;

    sodor_mem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .clock                           (clock),
        .reset                           (reset),
        .io_master_port_0_req_valid      (pValid[0]),
        .io_master_port_0_req_bits_addr  (pAddr[0]),
        .io_master_port_0_req_bits_data  (pData[0]),
        .io_master_port_0_req_bits_fcn   (pFcn[0]),
        .io_master_port_0_req_bits_typ   (pTyp[0]),
        .io_master_port_0_resp_valid     (rValid[0]),
        .io_master_port_0_resp_bits_data (rData[0]),
        .io_master_port_1_req_valid      (pValid[1]),
        .io_master_port_1_req_bits_addr  (pAddr[1]),
        .io_master_port_1_req_bits_data  (pData[1]),
        .io_master_port_1_req_bits_fcn   (pFcn[1]),
        .io_master_port_1_req_bits_typ   (pTyp[1]),
        .io_master_port_1_resp_valid     (rValid[1]),
        .io_master_port_1_resp_bits_data (rData[1]),
        .io_debug_port_req_valid         (pValid[2]),
        .io_debug_port_req_bits_addr     (pAddr[2]),
        .io_debug_port_req_bits_data     (pData[2]),
        .io_debug_port_req_bits_fcn      (pFcn[2]),
        .io_debug_port_req_bits_typ      (pTyp[2]),
        .io_debug_port_resp_valid        (rValid[2]),
        .io_debug_port_resp_bits_data    (rData[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct packed {
        logic [1:0]  port;
        logic        fcn;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic clearAll();
        pValid = '0;
        pFcn   = '0;
        pTyp   = '0;
        pAddr  = '0;
        pData  = '0;
    endtask

    task automatic setReq(input int port, input logic fcn, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] wdata);
        pValid[port] = 1'b1;
        pFcn[port]   = fcn;
        pTyp[port]   = typ;
        pAddr[port]  = addr;
        pData[port]  = wdata;
    endtask

    // Issue one request, then check silence, the single response, and silence again.
    task automatic doReq(input int id, input int port, input logic fcn, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        setReq(port, fcn, typ, addr, wdata);
        @(negedge clock);
        clearAll();
        for (int c = 1; c < LAT; c++) begin
            chk($sformatf("vec%0d early valid c%0d", id, c), 32'(rValid[port]), 32'd0);
            @(negedge clock);
        end
        chk($sformatf("vec%0d resp valid", id), 32'(rValid[port]), 32'd1);
        chk($sformatf("vec%0d resp data", id), rData[port], exp);
        @(negedge clock);
        chk($sformatf("vec%0d valid after", id), 32'(rValid[port]), 32'd0);
        chk($sformatf("vec%0d data idle", id), rData[port], 32'd0);
    endtask

    task automatic chkIdleAll(input string tag);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("%s p%0d valid", tag, p), 32'(rValid[p]), 32'd0);
            chk($sformatf("%s p%0d data", tag, p), rData[p], 32'd0);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        //            port  fcn  typ   addr          wdata          expected
        vecs[0]  = '{2'd2, 1'b1, 3'd3, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{2'd1, 1'b0, 3'd3, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2]  = '{2'd1, 1'b1, 3'd3, 32'h0000_80F0, 32'h80F0_7F01, 32'h0000_0000};
        vecs[3]  = '{2'd1, 1'b0, 3'd1, 32'h0000_80F3, 32'h0000_0000, 32'hFFFF_FF80};
        vecs[4]  = '{2'd1, 1'b0, 3'd5, 32'h0000_80F3, 32'h0000_0000, 32'h0000_0080};
        vecs[5]  = '{2'd1, 1'b0, 3'd2, 32'h0000_80F2, 32'h0000_0000, 32'hFFFF_80F0};
        vecs[6]  = '{2'd1, 1'b0, 3'd6, 32'h0000_80F0, 32'h0000_0000, 32'h0000_7F01};
        vecs[7]  = '{2'd1, 1'b0, 3'd1, 32'h0000_80F0, 32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{2'd1, 1'b0, 3'd2, 32'h0000_80F1, 32'h0000_0000, 32'h0000_7F01};
        vecs[9]  = '{2'd2, 1'b0, 3'd7, 32'h0000_80F2, 32'h0000_0000, 32'h80F0_7F01};
        vecs[10] = '{2'd0, 1'b0, 3'd0, 32'h0000_00F0, 32'h0000_0000, 32'h80F0_7F01};
        vecs[11] = '{2'd2, 1'b0, 3'd4, 32'h0000_40F0, 32'h0000_0000, 32'h80F0_7F01};
        vecs[12] = '{2'd1, 1'b1, 3'd3, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000};
        vecs[13] = '{2'd1, 1'b1, 3'd1, 32'h0000_0021, 32'hCDCD_CDAB, 32'h0000_0000};
        vecs[14] = '{2'd1, 1'b0, 3'd3, 32'h0000_0020, 32'h0000_0000, 32'h1122_AB44};
        vecs[15] = '{2'd1, 1'b1, 3'd2, 32'h0000_0023, 32'h1234_BEEF, 32'h0000_0000};
        vecs[16] = '{2'd2, 1'b0, 3'd3, 32'h0000_0020, 32'h0000_0000, 32'hBEEF_AB44};
        vecs[17] = '{2'd0, 1'b1, 3'd3, 32'h0000_0020, 32'hFFFF_FFFF, 32'hBEEF_AB44};
        vecs[18] = '{2'd1, 1'b0, 3'd3, 32'h0000_0020, 32'h0000_0000, 32'hBEEF_AB44};
        vecs[19] = '{2'd0, 1'b0, 3'd1, 32'h0000_0022, 32'h0000_0000, 32'hFFFF_FFEF};
        vecs[20] = '{2'd2, 1'b0, 3'd6, 32'h0000_0022, 32'h0000_0000, 32'h0000_BEEF};
        vecs[21] = '{2'd1, 1'b1, 3'd3, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000};
        vecs[22] = '{2'd2, 1'b0, 3'd5, 32'h0000_0021, 32'h0000_0000, 32'h0000_00AB};

        // Reset with a request presented; nothing may respond.
        clearAll();
        reset = 1'b0;
        @(negedge clock);
        setReq(2, 1'b0, 3'd3, 32'h0, 32'h0);
        repeat (LAT + 1) @(negedge clock);
        chkIdleAll("reset");
        clearAll();
        reset = 1'b1;

        for (int i = 0; i < NV; i++)
            doReq(i, int'(vecs[i].port), vecs[i].fcn, vecs[i].typ, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exp);

        // Same cycle: port0 reads 0x40 while port1 writes 5; then a back-to-back read.
        setReq(0, 1'b0, 3'd3, 32'h40, 32'h0);
        setReq(1, 1'b1, 3'd3, 32'h40, 32'h5);
        @(negedge clock);
        clearAll();
        setReq(0, 1'b0, 3'd3, 32'h40, 32'h0);
        @(negedge clock);
        clearAll();
        for (int c = 2; c < LAT; c++) @(negedge clock);
        chk("rbw p0 valid", 32'(rValid[0]), 32'd1);
        chk("rbw p0 old data", rData[0], 32'h0);
        chk("rbw p1 write valid", 32'(rValid[1]), 32'd1);
        chk("rbw p1 write data", rData[1], 32'h0);
        @(negedge clock);
        chk("rbw p0 second valid", 32'(rValid[0]), 32'd1);
        chk("rbw p0 new data", rData[0], 32'h5);
        chk("rbw p1 single resp", 32'(rValid[1]), 32'd0);
        @(negedge clock);
        chk("rbw p0 done", 32'(rValid[0]), 32'd0);

        // Same cycle, same word: port1 word write and debug halfword write; debug wins.
        setReq(1, 1'b1, 3'd3, 32'h0, 32'h1111_1111);
        setReq(2, 1'b1, 3'd2, 32'h0, 32'hFFFF_2222);
        @(negedge clock);
        clearAll();
        for (int c = 1; c < LAT; c++) @(negedge clock);
        chk("merge p1 valid", 32'(rValid[1]), 32'd1);
        chk("merge dbg valid", 32'(rValid[2]), 32'd1);
        chk("merge dbg data", rData[2], 32'h0);
        @(negedge clock);
        doReq(100, 1, 1'b0, 3'd3, 32'h0, 32'h0, 32'h1111_2222);

        // Reset one cycle after a read is accepted; a write presented during reset is dropped.
        setReq(1, 1'b0, 3'd3, 32'h10, 32'h0);
        @(negedge clock);
        clearAll();
        reset = 1'b0;
        setReq(2, 1'b1, 3'd3, 32'h10, 32'h0BAD_0BAD);
        @(negedge clock);
        chkIdleAll("midrst");
        clearAll();
        reset = 1'b1;
        setReq(1, 1'b0, 3'd3, 32'h10, 32'h0);
        @(negedge clock);
        clearAll();
        chkIdleAll("flush1");
        for (int c = 1; c < LAT; c++) begin
            if (c > 1) chkIdleAll($sformatf("flush%0d", c));
            @(negedge clock);
        end
        chk("postrst p1 valid", 32'(rValid[1]), 32'd1);
        chk("postrst p1 data", rData[1], 32'hDEAD_BEEF);
        chk("postrst dbg silent", 32'(rValid[2]), 32'd0);
        @(negedge clock);
        chk("postrst p1 single", 32'(rValid[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sodor_mem_responder.md
SODOR_MEM_RESPONDER -- requirements
Module: sodor_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit memory words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, meaning request-to-response cycles (1..4).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have, for P in {master_port_0, master_port_1, debug_port}: io_P_req_valid in 1; io_P_req_bits_addr in 32; io_P_req_bits_data in 32; io_P_req_bits_fcn in 1 (0 read, 1 write); io_P_req_bits_typ in 3.
REQ-006 SHALL have, for each P: io_P_resp_valid out 1; io_P_resp_bits_data out 32.

Function
REQ-007 SHALL accept a request on any port in every cycle where req_valid=1 and reset=1; no backpressure.
REQ-008 SHALL select word index addr[log2(DEPTH)+1:2]; higher address bits ignored (aliasing wrap).
REQ-009 SHALL decode typ: 1 B, 2 H, 3 W, 5 BU, 6 HU, 7 WU; 0 and 4 treated as W.
REQ-010 SHALL pick lanes: byte lane addr[1:0]; halfword lane addr[1] (addr[0] ignored); word ignores addr[1:0].
REQ-011 SHALL return reads right-justified: B/H sign-extended to 32 bits, BU/HU zero-extended, W/WU unchanged.
REQ-012 SHALL perform writes with byte enables from typ/lanes, taking data bits [7:0]/[15:0]/[31:0] replicated into the selected lane(s); unselected bytes unchanged.
REQ-013 SHALL treat master_port_0 as read-only: fcn=1 there performs no write and responds as a read.
REQ-014 SHALL sample read data from the array in the acceptance cycle (read-before-write: a write accepted in the same cycle is not visible).
REQ-015 SHALL commit a write at the end of its acceptance cycle; visible to reads accepted in the next cycle.
REQ-016 SHALL, on same-cycle writes to the same word from debug_port and master_port_1, apply master_port_1 first then debug_port bytes (debug wins on overlapping bytes).
REQ-017 SHALL assert io_P_resp_valid exactly LATENCY cycles after acceptance, for one cycle per accepted request, in order.
REQ-018 SHALL drive resp_bits_data = formatted read data for reads, 0 for writes; resp_bits_data = 0 whenever resp_valid=0.
REQ-019 SHALL implement a per-port LATENCY-deep valid/data shift pipeline; back-to-back requests produce back-to-back responses.
REQ-020 SHALL keep the three ports independent: traffic on one never delays or alters responses on another except via memory contents.

Reset
REQ-021 SHALL, while reset=0 at a rising edge, clear all pipeline stages; all resp_valid=0 and resp_bits_data=0 on the following cycle.
REQ-022 SHALL ignore requests presented while reset=0 (no write, no response).
REQ-023 SHALL discard in-flight responses when reset asserts mid-operation; no stale response after release.
REQ-024 SHALL NOT reset memory contents; array holds value across reset.
REQ-025 SHALL accept requests in the first cycle with reset=1.

Verification
REQ-026 SHALL cover: debug write W 0xDEADBEEF @0x10, then port1 read W @0x10 -> resp_valid after LATENCY, data 0xDEADBEEF.
REQ-027 SHALL cover: word 0x00000080F0 contents 0x80F07F01; port1 reads B @0x3 -> 0xFFFFFF80, BU @0x3 -> 0x00000080, H @0x2 -> 0xFFFF80F0, HU @0x0 -> 0x00007F01.
REQ-028 SHALL cover: port1 write B 0xAB @0x21 over 0x11223344 -> word becomes 0x1122AB44; write resp data 0.
REQ-029 SHALL cover: same cycle port0 read W @0x40 and port1 write 0x5 @0x40 (old 0x0) -> port0 returns 0x0; next-cycle read returns 0x5.
REQ-030 SHALL cover: same cycle port1 write W 0x11111111 and debug write H 0x2222 @0x0 lane 0 -> word 0x11112222.
REQ-031 SHALL cover: LATENCY=3, read accepted, reset=0 one cycle later -> no resp_valid ever for that read; memory retained; request in first post-reset cycle responds 3 cycles later.
